// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch master and a data master.
// Data normally wins; a streak counter guarantees a waiting fetch is served eventually.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    // fetch master
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    // data master
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_stall,
    // shared memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int STREAK_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam int WDOG_W   = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    // Fetches are always full-word reads.
    localparam logic [1:0] FETCH_OP = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic                drop_q;

    logic        busy;
    logic        starve;
    logic        grant_if;
    logic        grant_d;
    logic        timeout_hit;
    logic        done;
    logic [31:0] resp_data;

    // A flush in the arbitration cycle makes the fetch ineligible for that cycle.
    assign starve      = (streak_q == STREAK_W'(STARVE_LIMIT));
    assign grant_if    = (state_q == IDLE) && if_req && !if_flush && (!d_req || starve);
    assign grant_d     = (state_q == IDLE) && d_req && !grant_if;
    assign busy        = (state_q != IDLE);
    assign timeout_hit = busy && !mem_ready && (wdog_q == WDOG_W'(TIMEOUT - 1));
    assign done        = busy && (mem_ready || timeout_hit);
    assign resp_data   = mem_ready ? mem_rdata : 32'h0;

    assign mem_req  = busy;
    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        if_ack   = 1'b0;
        d_ack    = 1'b0;
        if_rdata = 32'h0;
        d_rdata  = 32'h0;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d = BUSY_IF;
                end else if (grant_d) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_IF: begin
                if (done) begin
                    state_d = IDLE;
                    if (!(drop_q || if_flush)) begin
                        if_ack   = 1'b1;
                        if_rdata = resp_data;
                    end
                end
            end
            BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                    d_ack   = 1'b1;
                    d_rdata = resp_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_op    <= 2'b00;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_op    <= FETCH_OP;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_op    <= d_op;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end
    end

    // Counts data grants handed out while a fetch was waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (state_q == IDLE) begin
            if (!if_req || grant_if) begin
                streak_q <= '0;
            end else if (grant_d && !starve) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end

    // Held at zero outside BUSY, so it always starts from zero on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (!busy || done) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 1'b0;
        end else if (state_q != BUSY_IF || done) begin
            drop_q <= 1'b0;
        end else if (if_flush) begin
            drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (timeout_hit) begin
            bus_err <= 1'b1;
        end
    end

    a_single_ack: assert property (@(posedge clk) disable iff (!rst)
        !(if_ack && d_ack));

    a_cmd_hold: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && !done) |=> (mem_req && $stable(mem_addr) && $stable(mem_we)));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while a fetch request is waiting.
REQ-002 Parameter TIMEOUT, default 255: the number of cycles a granted transaction waits for mem_ready before it is aborted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_ack.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_flush  in  1  pipeline clear; cancels delivery of an in-flight fetch.
REQ-008 if_rdata  out  32  fetch read data; valid only while if_ack=1.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request; held with d_we, d_op, d_addr, d_wdata stable until d_ack.
REQ-011 d_we, d_op  in  1, 2  data write enable and access size/type; passed through unchanged.
REQ-012 d_addr, d_wdata  in  32, 32  data address and store data.
REQ-013 d_rdata  out  32  load data; valid only while d_ack=1.
REQ-014 d_ack  out  1  one-cycle data completion pulse.
REQ-015 if_stall, d_stall  out  1, 1  pipeline stalls: if_req & ~if_ack and d_req & ~d_ack respectively.
REQ-016 mem_req  out  1  shared-port request; held until mem_ready.
REQ-017 mem_we, mem_op, mem_addr, mem_wdata  out  1, 2, 32, 32  registered shared-port command.
REQ-018 mem_ready, mem_rdata  in  1, 32  port completion and read data, valid the same cycle.
REQ-019 bus_err  out  1  sticky timeout flag.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY_IF, BUSY_D.
REQ-021 In IDLE, when a request is pending, the block SHALL latch the winner's command into the mem_* registers and move to the matching BUSY state on the next edge.
REQ-022 Priority: d_req SHALL win over if_req, except when if_req is pending and streak==STARVE_LIMIT; in that case the fetch SHALL win.
REQ-023 streak (3+ bits) SHALL be handled as follows:
- +1 (saturating) on each data grant made while if_req=1.
- cleared on each fetch grant.
- cleared on any IDLE cycle with if_req=0.
REQ-024 mem_req SHALL be 1 exactly while in BUSY_IF or BUSY_D, and 0 in IDLE.
REQ-025 In BUSY_x with mem_ready=1, x_ack SHALL be 1 and x_rdata SHALL equal mem_rdata that cycle; the next state SHALL be IDLE.
REQ-026 Minimum occupancy per transaction is one IDLE arbitration cycle plus one BUSY cycle; there is no back-to-back issue from BUSY.
REQ-027 wdog SHALL count cycles in BUSY_x, clear on entry to BUSY_x, and must be at least 8 bits wide.
REQ-028 If wdog reaches TIMEOUT-1 with mem_ready=0, the block SHALL:
- pulse x_ack with x_rdata=0;
- set bus_err;
- return to IDLE.
REQ-029 if_flush in BUSY_IF SHALL set a drop flag; when mem_ready then arrives, if_ack SHALL be suppressed and the state SHALL return to IDLE.
REQ-030 The drop flag SHALL clear on exit from BUSY_IF.
REQ-031 if_flush in IDLE SHALL block a fetch grant that cycle.
REQ-032 if_flush SHALL have no effect on BUSY_D.
REQ-033 mem_ready in IDLE SHALL be ignored.
REQ-034 if_ack and d_ack SHALL never both be 1 in the same cycle.

Reset
REQ-035 While rst=0, the block SHALL immediately force:
- state=IDLE;
- mem_req=0, mem_we=0, mem_op=0, mem_addr=0, mem_wdata=0;
- if_ack=0, d_ack=0, if_rdata=0, d_rdata=0;
- bus_err=0, streak=0, wdog=0, drop=0.
REQ-036 Reset asserted mid-transaction SHALL abandon that transaction with no ack after release.
REQ-037 Operation SHALL resume at the first rising edge after rst returns to 1.

Verification
REQ-038 Single fetch: if_req=1, if_addr=0x40, mem_ready=1 in the 2nd BUSY cycle with mem_rdata=0x1234ABCD -> mem_addr=0x40, if_ack one cycle with if_rdata=0x1234ABCD, if_stall=1 until that cycle.
REQ-039 Contention: if_req and d_req both asserted, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> data served first (mem_we=1, mem_wdata=0xDEADBEEF), fetch served next.
REQ-040 Starvation: d_req held continuously with if_req=1, memory always ready -> after exactly 4 data grants the 5th grant goes to the fetch.
REQ-041 Flush: if_flush pulsed during BUSY_IF, mem_ready 3 cycles later -> if_ack stays 0, state returns to IDLE, a pending d_req is granted next.
REQ-042 Timeout: mem_ready held 0 after a data grant -> d_ack=1 with d_rdata=0 in the 255th BUSY cycle, bus_err=1 and held until reset.
REQ-043 Async reset: rst driven 0 mid-BUSY_D, between clock edges -> mem_req=0 and bus_err=0 without waiting for a clock edge, no d_ack after release.
